// File: rtl/packet_route_fifo_if.sv
// Handshake bundle between the bit slicer, the route FIFO and its four consumers.
interface packet_route_fifo_if #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    // FIFO side
    modport slave (
        input  in_valid, in_data, in_addr, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_addr, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/packet_route_fifo.sv
// Route FIFO: buffers {addr, data} transfers and steers the head entry to
// one of four ports chosen by the top two address bits, counting deliveries.
module packet_route_fifo #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    packet_route_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [31:0]                o_pkt_cnt
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned NPORT   = 4;
    localparam int unsigned CNT_W   = 8;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wp;
    logic [PTR_W-1:0]   r_rp;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_cnt [NPORT];

    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [1:0]         w_port;
    logic [NPORT-1:0]   w_out_valid;

    // Head decode and handshake qualifiers; only registered state feeds ready/valid
    always_comb begin
        w_in_ready  = !i_reset && (r_level != LVL_W'(DEPTH));
        w_push      = bus.in_valid && w_in_ready;
        w_head      = r_mem[r_rp];
        w_port      = w_head[ENTRY_W-1 -: 2];
        w_out_valid = '0;
        if (r_level != '0) begin
            w_out_valid = NPORT'(1) << w_port;
        end
        w_pop       = |(w_out_valid & bus.out_ready);
    end

    // Payload storage; contents survive reset, only pointers are cleared
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= {bus.in_addr, bus.in_data};
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    // Per-port saturating delivery counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < int'(NPORT); p++) begin
                r_cnt[p] <= '0;
            end
        end else if (w_pop) begin
            for (int p = 0; p < int'(NPORT); p++) begin
                if ((w_port == 2'(p)) && (r_cnt[p] != {CNT_W{1'b1}})) begin
                    r_cnt[p] <= r_cnt[p] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_head[DATA_W-1:0];
    assign bus.out_addr  = w_head[ENTRY_W-1:DATA_W];
    assign o_level       = r_level;
    assign o_pkt_cnt     = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
endmodule
